conv_window_gen: RTL and testbench
==================================

Name: conv_window_gen

Overview:
- Upstream neighbour of the convolution stage.
- Accepts a 28x28 image as a raster-order stream of signed pixels.
- Buffers K-1 rows in line buffers and emits every valid KxK sliding window (stride 1) as a flattened tap bus for the conv stage's data_00..data_44 inputs.
- Replaces random-access indexing into a whole-image memory with a streaming valid/ready front end.

Parameters:
DATA_W, 32, signed pixel width
IMG_W, 28, image columns
IMG_H, 28, image rows
K, 5, window edge (taps = K*K)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  reset, synchronous, active-high
in_valid  in  1  pixel present on in_pixel
in_pixel  in  DATA_W  signed pixel, raster order (row-major, column fastest)
in_ready  out  1  block can accept a pixel this cycle
out_valid  out  1  window present on out_win
out_ready  in  1  consumer accepts window this cycle
out_win  out  K*K*DATA_W  taps; slice [(i*K+j)*DATA_W +: DATA_W] = pixel(row out_y+i, col out_x+j)
out_x  out  5  window left column, 0..IMG_W-K
out_y  out  5  window top row, 0..IMG_H-K
frame_done  out  1  high alongside the last window of a frame (out_x=out_y=IMG_W-K)

Behaviour:
- Reset is synchronous active-high on clk. In reset: out_valid=0, out_win=0, out_x=0, out_y=0, frame_done=0, row/col counters=0.
- Line-buffer and window-register contents are don't-care after reset.
- in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready.
- Output handshake: transfer = out_valid && out_ready. While out_valid && !out_ready, out_win/out_x/out_y/frame_done hold stable.
- On accept of pixel (r,c):
  - Column vector v[i] = linebuf[i][c] for i<K-1, and v[K-1] = in_pixel.
  - Window register shifts one column left and inserts v as column K-1.
  - linebuf[i][c] <= linebuf[i+1][c] for i<K-2; linebuf[K-2][c] <= in_pixel.
  - c increments. At c=IMG_W-1, c wraps to 0 and r increments. At r=IMG_H-1, c=IMG_W-1, r wraps to 0 (next frame).
- Window emit: if the accepted pixel has r>=K-1 and c>=K-1, then next cycle:
  - out_valid=1, out_win = updated window, out_x=c-K+1, out_y=r-K+1.
  - frame_done=1 iff r=IMG_H-1 and c=IMG_W-1; otherwise frame_done=0.
  - Latency is exactly 1 cycle from accept to out_valid.
- If an accept produces no window (r<K-1 or c<K-1) and the current window transfers, out_valid drops to 0 next cycle.
- If a new window and a transfer happen in the same cycle, out_valid stays 1 with the new window, so sustained throughput is 1 window/cycle.
- No windows span row boundaries: columns 0..K-2 of each row only fill the window register.
- 576 windows per 28x28 frame.
- Back-to-back frames: row-0 pixels of the next frame may follow the last pixel immediately. Stale line-buffer data is never emitted because rows < K-1 produce no windows.
- Reset mid-frame: the partial frame is discarded, out_valid clears, and the next accepted pixel is treated as (0,0).
- Taps pass through unmodified: signed, no arithmetic, no saturation.
- in_valid is ignored while in_ready=0. The pixel must be held by the producer per valid/ready rules.

Test Plan:
- Ramp image pixel=r*28+c, in_valid=1 continuously, out_ready=1:
  - first out_valid comes 1 cycle after accepting the 117th pixel (index 116), with out_x=0, out_y=0, tap00=0, tap04=4, tap40=112, tap44=116;
  - exactly 576 windows total;
  - last window has tap44=783, out_x=out_y=23, frame_done=1 for one cycle only.
- Same ramp with out_ready toggling 1-0-0-1 pattern:
  - window sequence is identical to the full-rate run (no drops or duplicates);
  - out_win is stable while stalled;
  - in_ready=0 exactly when out_valid=1 and out_ready=0.
- Two ramp frames back-to-back: 1152 windows; the second frame's first window again has tap00=0, out_x=0, out_y=0.
- rst asserted for one cycle after 300 pixels of frame 1, then a full frame:
  - out_valid=0 in the cycle after rst;
  - exactly 576 windows follow, matching the golden ramp.
- Image of alternating -1 / 0x7FFFFFFF pixels: taps reproduce the signed values bit-exact against a software 5x5 extraction.
- Random in_valid (50%) with random out_ready (50%) for 3 frames: scoreboard compares every window against a software model. No mismatches; the count of frame_done pulses is 3.

Source files
------------

// File: rtl/conv_window_gen.sv
// conv_window_gen: streams raster-order pixels through K-1 line buffers
// and emits every KxK stride-1 window as a flat tap bus.
module conv_window_gen #(
   parameter int DATA_W = 32,
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28,
   parameter int K      = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DATA_W-1:0]     in_pixel,
   output logic                  in_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [K*K*DATA_W-1:0] out_win,
   output logic [4:0]            out_x,
   output logic [4:0]            out_y,
   output logic                  frame_done
);

   localparam logic [4:0] KM1   = 5'(K - 1);
   localparam logic [4:0] C_MAX = 5'(IMG_W - 1);
   localparam logic [4:0] R_MAX = 5'(IMG_H - 1);

   logic [4:0]        col_q, col_d;
   logic [4:0]        row_q, row_d;
   logic [4:0]        x_q, x_d;
   logic [4:0]        y_q, y_d;
   logic              valid_q, valid_d;
   logic              done_q, done_d;
   logic [DATA_W-1:0] lb_q  [K-1][IMG_W];
   logic [DATA_W-1:0] lb_d  [K-1][IMG_W];
   logic [DATA_W-1:0] win_q [K][K];
   logic [DATA_W-1:0] win_d [K][K];
   logic              accept;
   logic              emit;
   logic              xfer;

   always_comb begin
      in_ready = !valid_q || out_ready;
      accept   = in_valid && in_ready;
      xfer     = valid_q && out_ready;
      emit     = accept && (row_q >= KM1) && (col_q >= KM1);
      col_d    = col_q;
      row_d    = row_q;
      lb_d     = lb_q;
      win_d    = win_q;
      x_d      = x_q;
      y_d      = y_q;
      valid_d  = valid_q;
      done_d   = done_q;
      if (accept) begin
         // lb[0] holds the oldest row, so it becomes the window's top tap
         for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K - 1; j++) begin
               win_d[i][j] = win_q[i][j+1];
            end
         end
         for (int i = 0; i < K - 1; i++) begin
            win_d[i][K-1] = lb_q[i][col_q];
         end
         win_d[K-1][K-1] = in_pixel;
         for (int i = 0; i < K - 2; i++) begin
            lb_d[i][col_q] = lb_q[i+1][col_q];
         end
         lb_d[K-2][col_q] = in_pixel;
         if (col_q == C_MAX) begin
            col_d = '0;
            row_d = (row_q == R_MAX) ? 5'd0 : row_q + 5'd1;
         end else begin
            col_d = col_q + 5'd1;
         end
      end
      if (emit) begin
         valid_d = 1'b1;
         x_d     = col_q - KM1;
         y_d     = row_q - KM1;
         done_d  = (row_q == R_MAX) && (col_q == C_MAX);
      end else if (xfer) begin
         valid_d = 1'b0;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_q   <= '0;
         row_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
               win_q[i][j] <= '0;
            end
         end
      end else begin
         col_q   <= col_d;
         row_q   <= row_d;
         x_q     <= x_d;
         y_q     <= y_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         win_q   <= win_d;
      end
   end

   always_ff @(posedge clk) begin
      lb_q <= lb_d;
   end

   always_comb begin
      out_win = '0;
      for (int i = 0; i < K; i++) begin
         for (int j = 0; j < K; j++) begin
            out_win[(i*K+j)*DATA_W +: DATA_W] = win_q[i][j];
         end
      end
   end

   assign out_valid  = valid_q;
   assign out_x      = x_q;
   assign out_y      = y_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: ramp/alt/random frames checked against
// a window-extraction scoreboard plus a table of hand-derived taps.
module tb_conv_window_gen;

   localparam int DW = 32;
   localparam int IW = 28;
   localparam int IH = 28;
   localparam int K  = 5;
   localparam int WB = K * K * DW;
   localparam int NP = IW * IH;

   typedef struct {
      logic [WB-1:0] w;
      logic [4:0]    x;
      logic [4:0]    y;
      logic          fd;
   } win_t;

   typedef struct {
      int n;
      int i;
      int j;
      int val;
      int x;
      int y;
   } tap_vec_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_pixel = '0;
   logic          in_ready;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [WB-1:0] out_win;
   logic [4:0]    out_x;
   logic [4:0]    out_y;
   logic          frame_done;

   conv_window_gen #(
      .DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .K(K)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_pixel(in_pixel),
      .in_ready(in_ready),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_win(out_win),
      .out_x(out_x),
      .out_y(out_y),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int            n_chk = 0;
   int            n_err = 0;
   logic [DW-1:0] img [IH][IW];
   logic [DW-1:0] pix_q [$];
   win_t          exp_q [$];
   win_t          got_q [$];
   int            pcnt = 0;
   int            cyc = 0;
   int            mode = 0;
   bit            vrand = 0;
   bit            exp_ov = 0;
   bit            pend = 0;
   int            fd_cycles = 0;
   int            fd_xfers = 0;
   int            acc116_cyc = -1;
   int            first_ov_cyc = -1;
   tap_vec_t      tv [9];

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic chk_win(string nm, logic [WB-1:0] act, logic [WB-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [WB-1:0] window_at(int y, int x);
      logic [WB-1:0] w;
      w = '0;
      for (int i = 0; i < K; i++) begin
         for (int j = 0; j < K; j++) begin
            w[(i*K+j)*DW +: DW] = img[y+i][x+j];
         end
      end
      return w;
   endfunction

   // A window with top-left (y,x) is due when pixel (y+K-1, x+K-1) arrives
   task automatic push_frame(int npix);
      for (int idx = 0; idx < npix; idx++) begin
         int   r;
         int   c;
         win_t e;
         r = idx / IW;
         c = idx % IW;
         pix_q.push_back(img[r][c]);
         if (r >= K - 1 && c >= K - 1) begin
            e.w  = window_at(r - K + 1, c - K + 1);
            e.x  = 5'(c - K + 1);
            e.y  = 5'(r - K + 1);
            e.fd = (r == IH - 1) && (c == IW - 1);
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic fill_ramp();
      for (int r = 0; r < IH; r++)
         for (int c = 0; c < IW; c++)
            img[r][c] = DW'(r * IW + c);
   endtask

   task automatic fill_alt();
      for (int r = 0; r < IH; r++)
         for (int c = 0; c < IW; c++)
            img[r][c] = ((r * IW + c) % 2 == 0) ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
   endtask

   task automatic fill_rand();
      for (int r = 0; r < IH; r++)
         for (int c = 0; c < IW; c++)
            img[r][c] = $urandom;
   endtask

   task automatic step();
      bit   acc;
      bit   xfer;
      bit   emit;
      int   idx;
      win_t e;
      @(negedge clk);
      cyc++;
      chk("out_valid", 64'(out_valid), 64'(exp_ov));
      if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
      if (frame_done) fd_cycles++;
      case (mode)
         0:       out_ready = 1'b1;
         1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
         default: out_ready = ($urandom_range(0, 1) == 1);
      endcase
      if (!pend) begin
         in_valid = (pix_q.size() > 0) && (!vrand || $urandom_range(0, 1) == 1);
         if (in_valid) in_pixel = pix_q[0];
      end
      #1;
      chk("in_ready", 64'(in_ready), 64'(!exp_ov || out_ready));
      acc  = in_valid && in_ready;
      xfer = out_valid && out_ready;
      pend = in_valid && !in_ready;
      emit = 0;
      if (xfer) begin
         got_q.push_back(win_t'{out_win, out_x, out_y, frame_done});
         if (frame_done) fd_xfers++;
         if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL extra_window: got x=%0d y=%0d want none", out_x, out_y);
         end else begin
            e = exp_q.pop_front();
            chk_win("win", out_win, e.w);
            chk("out_x", 64'(out_x), 64'(e.x));
            chk("out_y", 64'(out_y), 64'(e.y));
            chk("frame_done", 64'(frame_done), 64'(e.fd));
         end
      end
      if (acc) begin
         idx  = pcnt % NP;
         emit = (idx / IW >= K - 1) && (idx % IW >= K - 1);
         if (idx == 116 && acc116_cyc < 0) acc116_cyc = cyc;
         void'(pix_q.pop_front());
         pcnt++;
      end
      exp_ov = emit || (exp_ov && !xfer);
   endtask

   task automatic run_phase(string nm, int budget);
      int guard;
      guard = 0;
      while ((pix_q.size() > 0 || exp_q.size() > 0 || exp_ov) && guard < budget) begin
         step();
         guard++;
      end
      if (guard >= budget) begin
         n_chk++;
         n_err++;
         $display("FAIL %s_timeout: got %0d windows pending want 0", nm, exp_q.size());
         pix_q.delete();
         exp_q.delete();
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b0;
      pend     = 0;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_x", 64'(out_x), 64'd0);
      chk("rst_out_y", 64'(out_y), 64'd0);
      pcnt   = 0;
      exp_ov = 0;
   endtask

   initial begin
      tv[0] = '{0,   0, 0, 0,   0,  0};
      tv[1] = '{0,   0, 4, 4,   0,  0};
      tv[2] = '{0,   4, 0, 112, 0,  0};
      tv[3] = '{0,   4, 4, 116, 0,  0};
      tv[4] = '{24,  0, 0, 28,  0,  1};
      tv[5] = '{30,  0, 0, 34,  6,  1};
      tv[6] = '{30,  2, 2, 92,  6,  1};
      tv[7] = '{575, 0, 0, 667, 23, 23};
      tv[8] = '{575, 4, 4, 783, 23, 23};

      repeat (2) @(negedge clk);
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk_win("reset_out_win", out_win, '0);
      chk("reset_out_x", 64'(out_x), 64'd0);
      chk("reset_out_y", 64'(out_y), 64'd0);
      chk("reset_frame_done", 64'(frame_done), 64'd0);
      chk("reset_in_ready", 64'(in_ready), 64'd1);
      rst = 1'b0;

      // full-rate ramp
      fill_ramp();
      push_frame(NP);
      mode = 0;
      vrand = 0;
      got_q.delete();
      fd_cycles = 0;
      run_phase("ramp", 3000);
      chk("ramp_count", 64'(got_q.size()), 64'd576);
      chk("ramp_fd_cycles", 64'(fd_cycles), 64'd1);
      chk("first_latency", 64'(first_ov_cyc - acc116_cyc), 64'd1);
      for (int k = 0; k < 9; k++) begin
         if (got_q.size() > tv[k].n) begin
            win_t g;
            g = got_q[tv[k].n];
            chk($sformatf("tap_n%0d_%0d%0d", tv[k].n, tv[k].i, tv[k].j),
                64'(g.w[(tv[k].i*K+tv[k].j)*DW +: DW]), 64'(tv[k].val));
            chk($sformatf("tap_n%0d_x", tv[k].n), 64'(g.x), 64'(tv[k].x));
            chk($sformatf("tap_n%0d_y", tv[k].n), 64'(g.y), 64'(tv[k].y));
         end else begin
            n_chk++;
            n_err++;
            $display("FAIL tap_n%0d: got no window want one", tv[k].n);
         end
      end

      // ramp with 1-0-0-1 out_ready
      push_frame(NP);
      mode = 1;
      got_q.delete();
      run_phase("stall", 6000);
      chk("stall_count", 64'(got_q.size()), 64'd576);

      // two frames back-to-back
      push_frame(NP);
      push_frame(NP);
      mode = 0;
      got_q.delete();
      fd_xfers = 0;
      run_phase("b2b", 6000);
      chk("b2b_count", 64'(got_q.size()), 64'd1152);
      chk("b2b_fd", 64'(fd_xfers), 64'd2);
      if (got_q.size() > 576) begin
         chk("b2b_f2_tap00", 64'(got_q[576].w[DW-1:0]), 64'd0);
         chk("b2b_f2_x", 64'(got_q[576].x), 64'd0);
         chk("b2b_f2_y", 64'(got_q[576].y), 64'd0);
      end

      // reset after 300 pixels, then a full frame
      push_frame(300);
      run_phase("partial", 2000);
      do_reset();
      push_frame(NP);
      got_q.delete();
      run_phase("post_rst", 3000);
      chk("post_rst_count", 64'(got_q.size()), 64'd576);

      // signed extremes
      fill_alt();
      push_frame(NP);
      mode = 2;
      got_q.delete();
      run_phase("alt", 6000);
      chk("alt_count", 64'(got_q.size()), 64'd576);

      // random traffic, three random frames
      vrand = 1;
      mode = 2;
      got_q.delete();
      fd_xfers = 0;
      for (int f = 0; f < 3; f++) begin
         fill_rand();
         push_frame(NP);
      end
      run_phase("rand", 40000);
      chk("rand_count", 64'(got_q.size()), 64'd1728);
      chk("rand_fd", 64'(fd_xfers), 64'd3);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
